flex_shift_reg: RTL and testbench
=================================

// Module: flex_shift_reg
// PURPOSE
// - Parameterizable bidirectional shift register; serial-in/parallel-out and parallel-in/serial-out.
// - Shared building block for the USB 1.0 RX (deserialize) and TX (serialize) datapaths.
// - Parallel load, selectable shift direction, fully registered state.
// PARAMETERS
// - SIZE       default 4   register width in bits, legal range 2..64
// - MSB_FIRST  default 1   1: shift toward MSB; 0: shift toward LSB
// - RST_VALUE  default '1  register value after reset (all ones = USB idle level)
// PORTS
// - clk            in   1     rising-edge clock, single clock domain
// - n_rst          in   1     reset; synchronous, active-high (1 = reset, sampled on clk rising edge)
// - shift_enable   in   1     shift one position this cycle
// - load_enable    in   1     load parallel_in this cycle
// - serial_in      in   1     bit shifted in
// - parallel_in    in   SIZE  parallel load data
// - serial_out     out  1     bit leaving the register
// - parallel_out   out  SIZE  register contents
// - parity_out     out  1     only with FLEX_SR_PARITY_EN; see CONFIGURATION
// BEHAVIOUR
// - State q[SIZE-1:0] updates only on clk rising edge.
// - parallel_out = q (no combinational path from inputs).
// - Priority per edge: n_rst > load_enable > shift_enable > hold.
// - n_rst=1: q <= RST_VALUE, so parallel_out = RST_VALUE and serial_out = 1 for the default.
//   Overrides load/shift on the same edge.
// - load_enable=1: q <= parallel_in. A simultaneous shift_enable is ignored.
// - Shift with MSB_FIRST=1: q <= {q[SIZE-2:0], serial_in}; serial_out = q[SIZE-1].
// - Shift with MSB_FIRST=0: q <= {serial_in, q[SIZE-1:1]}; serial_out = q[0].
// - serial_out is a combinational decode of q only.
//   Before a shift it shows the bit about to leave; the new value is visible one cycle after the edge.
// - Hold: q unchanged when neither enable is set.
// - Latency: parallel_in -> parallel_out is 1 cycle. A serial_in bit reaches the serial_out
//   position after SIZE shifts.
// - Reset asserted mid-shift or mid-load: reset wins on that edge; there is no partial state.
// - X on serial_in is not masked: it propagates only when shift_enable=1.
// CONFIGURATION
// - Macro FLEX_SR_PARITY_EN.
// - Defined: adds output port parity_out = ^q (even parity of current contents), combinational from q.
//   Reset value of parity_out = ^RST_VALUE; for the default this is 0 when SIZE is even.
// - Undefined: port parity_out is absent and there is no parity logic. All other behaviour is identical.
// TESTING (SIZE=8 unless noted)
// - Reset: assert n_rst for 2 edges, release at negedge
//   -> parallel_out=8'hFF, serial_out=1 on the first edge while n_rst=1.
// - Load: parallel_in=8'hA5, load_enable=1 for 1 cycle
//   -> parallel_out=8'hA5 next cycle; serial_out=1 (MSB_FIRST=1).
// - MSB_FIRST=1 serialize: after loading 8'hA5, shift 8 times with serial_in=0
//   -> serial_out sequence 1,0,1,0,0,1,0,1; final parallel_out=8'h00.
// - MSB_FIRST=0 deserialize: from reset, shift in 1,0,0,0,0,0,0,0
//   -> parallel_out=8'h01.
// - Priority: load_enable=1 and shift_enable=1 with parallel_in=8'h3C -> parallel_out=8'h3C.
//   n_rst=1 together with load_enable=1 -> parallel_out=8'hFF.
// - Parity (FLEX_SR_PARITY_EN): load 8'h07 -> parity_out=1; then load 8'h03 -> parity_out=0.

Source files
------------

// File: rtl/flex_shift_reg.sv
// flex_shift_reg: parameterizable bidirectional shift register with parallel load.
// Serves as the serializer (PISO) and deserializer (SIPO) for the USB 1.0 TX/RX
// datapaths.
// The optional even-parity output is enabled by defining FLEX_SR_PARITY_EN.
// When it is enabled, parity_out = ^q.
// Update priority on every rising edge: reset > load > shift > hold.
// All outputs are decoded from the registered state only. No input reaches an
// output combinationally.
module flex_shift_reg #(
  parameter int unsigned      SIZE      = 4,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [SIZE-1:0]  RST_VALUE = '1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            shift_enable,
  input  logic            load_enable,
  input  logic            serial_in,
  input  logic [SIZE-1:0] parallel_in,
`ifdef FLEX_SR_PARITY_EN
  output logic            parity_out,
`endif
  output logic            serial_out,
  output logic [SIZE-1:0] parallel_out
);

  // A one-bit register has no defined shift direction. 64 bits is the upper
  // bound the USB datapaths were sized for.
  if (SIZE < 2 || SIZE > 64) begin : g_size_chk
    $error("flex_shift_reg: SIZE must be in 2..64");
  end

  logic [SIZE-1:0] q_q;
  logic [SIZE-1:0] q_d;
  logic [SIZE-1:0] shifted;

  // Shift path. The direction is fixed at elaboration, so only one shape exists
  // in hardware.
  if (MSB_FIRST) begin : g_msb
    assign shifted    = {q_q[SIZE-2:0], serial_in};
    assign serial_out = q_q[SIZE-1];
  end else begin : g_lsb
    assign shifted    = {serial_in, q_q[SIZE-1:1]};
    assign serial_out = q_q[0];
  end

  // Next state. Load takes precedence over shift. Reset is applied in the register.
  always_comb begin
    q_d = q_q;
    if (load_enable)       q_d = parallel_in;
    else if (shift_enable) q_d = shifted;
  end

  // State register with synchronous active-high reset. Reset overrides any enable
  // asserted on the same edge, so no partial update is possible.
  always_ff @(posedge clk) begin
    if (n_rst) q_q <= RST_VALUE;
    else       q_q <= q_d;
  end

  assign parallel_out = q_q;

`ifdef FLEX_SR_PARITY_EN
  assign parity_out = ^q_q;
`endif

endmodule

// File: tb/tb_flex_shift_reg.sv
// Self-checking bench for flex_shift_reg at SIZE=8.
// Two instances (MSB-first and LSB-first) receive identical stimulus.
// A behavioural model predicts both instances. The model register is a plain byte
// updated with shift/or arithmetic.
// A negedge compare process checks every cycle after the first reset.
// Literal checks pin the model against hand-derived values.
module tb_flex_shift_reg;

  logic       clk = 1'b0;
  logic       n_rst, shift_enable, load_enable, serial_in;
  logic [7:0] parallel_in;
  logic       so_m, so_l;
  logic [7:0] po_m, po_l;
`ifdef FLEX_SR_PARITY_EN
  logic       par_m, par_l;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flex_shift_reg #(.SIZE(8), .MSB_FIRST(1'b1), .RST_VALUE(8'hFF)) u_msb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .load_enable(load_enable),
    .serial_in(serial_in), .parallel_in(parallel_in),
`ifdef FLEX_SR_PARITY_EN
    .parity_out(par_m),
`endif
    .serial_out(so_m), .parallel_out(po_m));

  flex_shift_reg #(.SIZE(8), .MSB_FIRST(1'b0), .RST_VALUE(8'hFF)) u_lsb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .load_enable(load_enable),
    .serial_in(serial_in), .parallel_in(parallel_in),
`ifdef FLEX_SR_PARITY_EN
    .parity_out(par_l),
`endif
    .serial_out(so_l), .parallel_out(po_l));

  // Behavioural model: a byte per instance plus a flag marking it as known.
  int unsigned m_msb, m_lsb;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (n_rst === 1'b1) begin
      m_msb = 8'hFF; m_lsb = 8'hFF; m_valid = 1'b1;
    end else if (load_enable) begin
      m_msb = parallel_in; m_lsb = parallel_in;
    end else if (shift_enable) begin
      m_msb = ((m_msb * 2) + serial_in) % 256;
      m_lsb = (m_lsb / 2) + (serial_in ? 128 : 0);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model po_msb", po_m, m_msb[7:0]);
      chk("model po_lsb", po_l, m_lsb[7:0]);
      chk("model so_msb", {7'd0, so_m}, {7'd0, m_msb[7]});
      chk("model so_lsb", {7'd0, so_l}, {7'd0, m_lsb[0]});
`ifdef FLEX_SR_PARITY_EN
      chk("model par_msb", {7'd0, par_m}, {7'd0, ^m_msb[7:0]});
      chk("model par_lsb", {7'd0, par_l}, {7'd0, ^m_lsb[7:0]});
`endif
    end
  end

  // Drive one cycle of inputs, then wait until the following negedge.
  task automatic cyc(input logic r, input logic ld, input logic sh, input logic si,
                     input logic [7:0] pi);
    n_rst = r; load_enable = ld; shift_enable = sh; serial_in = si; parallel_in = pi;
    @(negedge clk);
  endtask

  logic [7:0] pat;
  logic [7:0] rv;

  initial begin
    n_rst = 1'b1; load_enable = 1'b0; shift_enable = 1'b0; serial_in = 1'b0; parallel_in = 8'h00;
    @(negedge clk);
    // Reset.
    chk("reset po", po_m, 8'hFF);
    chk("reset so", {7'd0, so_m}, 8'h01);
    cyc(1, 0, 0, 0, 8'h00);
    // Load A5, then serialize MSB first.
    cyc(0, 1, 0, 0, 8'hA5);
    chk("load po", po_m, 8'hA5);
    chk("load so", {7'd0, so_m}, 8'h01);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("ser bit", {7'd0, so_m}, {7'd0, pat[7-i]});
      cyc(0, 0, 1, 0, 8'h00);
    end
    chk("ser final", po_m, 8'h00);
    // Deserialize LSB first from reset.
    cyc(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, (i == 0), 8'h00);
    chk("deser lsb", po_l, 8'h01);
    chk("deser msb", po_m, 8'h80);
    // Hold.
    cyc(0, 0, 0, 1, 8'h55);
    chk("hold", po_l, 8'h01);
    // Priority.
    cyc(0, 1, 1, 1, 8'h3C);
    chk("ld>sh", po_m, 8'h3C);
    chk("ld>sh lsb", po_l, 8'h3C);
    cyc(1, 1, 1, 0, 8'h12);
    chk("rst>ld", po_m, 8'hFF);
`ifdef FLEX_SR_PARITY_EN
    cyc(0, 1, 0, 0, 8'h07);
    chk("parity 07", {7'd0, par_m}, 8'h01);
    cyc(0, 1, 0, 0, 8'h03);
    chk("parity 03", {7'd0, par_m}, 8'h00);
`endif
    // Randomized traffic. Reset is rare; load and shift overlap sometimes.
    for (int i = 0; i < 3000; i++) begin
      rv = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) != 0), $urandom_range(0, 1), rv);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
